// File: rtl/sqrt_sched.sv
// sqrt_sched: shared 8.8 fixed-point square-root engine with a two-port
// round-robin front end. One result bit is resolved per clock.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures an operand
// CALC  | iterating, one result bit per edge, MSB first
module sqrt_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  a0,
  input  logic        req1,
  input  logic [7:0]  a1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        owner,
  output logic [15:0] out
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] x;
  logic [15:0] res;
  logic [3:0]  i;
  logic        last;
  logic        cur;

  logic        any_req;
  logic        sel;
  logic        grant_ok;
  logic        do_grant;
  logic [7:0]  opnd;
  logic [15:0] trial;
  logic [31:0] sq;
  logic [15:0] res_nxt;

  // Arbitration, trial square and next state. A grant is accepted in IDLE
  // and also on the final iteration edge so back-to-back requests lose no cycle.
  always_comb begin
    state_nxt = state;
    any_req   = req0 | req1;
    sel       = (req0 & req1) ? ~last : req1;
    opnd      = sel ? a1 : a0;
    grant_ok  = (state == IDLE) || (i == 4'd0);
    do_grant  = any_req & grant_ok;
    trial     = res | (16'd1 << i);
    sq        = {16'h0000, trial} * {16'h0000, trial};
    res_nxt   = (sq <= x) ? trial : res;
    case (state)
      IDLE: if (do_grant) state_nxt = CALC;
      CALC: if (i == 4'd0) state_nxt = do_grant ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: iteration, result/owner capture on the last bit, operand capture on grant.
  // A grant on the final edge overrides the iteration updates of res and i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= 32'd0;
      res   <= 16'd0;
      i     <= 4'd0;
      last  <= 1'b1;
      cur   <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done  <= 1'b0;
      owner <= 1'b0;
      out   <= 16'h0000;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      if (state == CALC) begin
        res <= res_nxt;
        i   <= i - 4'd1;
        if (i == 4'd0) begin
          out   <= res_nxt;
          owner <= cur;
          done  <= 1'b1;
        end
      end
      if (do_grant) begin
        x    <= {8'h00, opnd, 16'h0000};
        res  <= 16'd0;
        i    <= 4'd15;
        last <= sel;
        cur  <= sel;
        gnt0 <= ~sel;
        gnt1 <= sel;
      end
    end
  end

  assign busy = (state == CALC);

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed testbench for sqrt_sched with hand-computed expected results.
module tb_sqrt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  a0, a1;
  logic        gnt0, gnt1, busy, done, owner;
  logic [15:0] out;

  int tests = 0;
  int fails = 0;

  sqrt_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .req1(req1), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .out(out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_one(input logic r, input logic [7:0] a, input logic [15:0] exp, input string tag);
    if (r) begin req1 = 1'b1; a1 = a; end
    else   begin req0 = 1'b1; a0 = a; end
    tick();
    chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, r ? 32'd2 : 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(tag);
    chk({tag, "_out"}, {16'd0, out}, {16'd0, exp});
    chk({tag, "_owner"}, {31'd0, owner}, {31'd0, r});
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [7:0]  sweep_a [6]  = '{8'd0, 8'd1, 8'd4, 8'd16, 8'd200, 8'd255};
    logic [15:0] sweep_e [6]  = '{16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0E24, 16'h0FF7};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a0 = 8'd0; a1 = 8'd0;
    repeat (3) tick();
    chk("rst_outputs", {12'd0, gnt0, gnt1, busy, done, owner, out}, 32'd0);
    #2 rst = 1'b0;
    tick();

    // Basic timing: a0=2
    req0 = 1'b1; a0 = 8'd2;
    tick();
    chk("t1_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (k < 15) tick();
    end
    chk("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("t1_busy_cycles", busy_cnt, 32'd16);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
    chk("t1_out", {16'd0, out}, 32'h016A);
    chk("t1_owner", {31'd0, owner}, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // Sweep on requester 1
    for (int k = 0; k < 6; k++) begin
      run_one(1'b1, sweep_a[k], sweep_e[k], $sformatf("sweep%0d", k));
      tick();
    end

    // Contention: last=1, so requester 0 is granted first
    req0 = 1'b1; a0 = 8'd4; req1 = 1'b1; a1 = 8'd16;
    tick();
    chk("rr_gnt_first", {30'd0, gnt1, gnt0}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      repeat (15) tick();
      chk($sformatf("rr%0d_no_early_done", k), {31'd0, done}, 32'd0);
      tick();
      chk($sformatf("rr%0d_done", k), {31'd0, done}, 32'd1);
      chk($sformatf("rr%0d_out", k), {16'd0, out}, (k % 2 == 0) ? 32'h0200 : 32'h0400);
      chk($sformatf("rr%0d_owner", k), {31'd0, owner}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_gnt", k), {30'd0, gnt1, gnt0},
          (k == 3) ? 32'd0 : ((k % 2 == 0) ? 32'd2 : 32'd1));
      chk($sformatf("rr%0d_busy", k), {31'd0, busy}, (k == 3) ? 32'd0 : 32'd1);
    end
    tick();

    // Operand change during CALC is ignored
    req0 = 1'b1; a0 = 8'd9;
    tick();
    chk("hold_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0; a0 = 8'd255;
    repeat (8) tick();
    a0 = 8'd77;
    wait_done("hold");
    chk("hold_out", {16'd0, out}, 32'h0300);
    repeat (5) tick();
    chk("hold_out_kept", {16'd0, out}, 32'h0300);
    chk("hold_no_done", {31'd0, done}, 32'd0);

    // Reset at iteration 8 of a0=200
    req0 = 1'b1; a0 = 8'd200;
    tick();
    req0 = 1'b0;
    repeat (8) tick();
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {16'd0, out}, 32'h0000);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    tick();
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 32'd0);
    req0 = 1'b1; a0 = 8'd1; req1 = 1'b1; a1 = 8'd4;
    tick();
    chk("rst_rr_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    wait_done("rst_re");
    chk("rst_re_out", {16'd0, out}, 32'h0100);
    chk("rst_re_owner", {31'd0, owner}, 32'd0);
    tick();

    // req0 held through done: back-to-back grant at E16
    req0 = 1'b1; a0 = 8'd16;
    tick();
    chk("b2b_gnt0", {31'd0, gnt0}, 32'd1);
    repeat (15) tick();
    tick();
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_out1", {16'd0, out}, 32'h0400);
    chk("b2b_gnt0_again", {31'd0, gnt0}, 32'd1);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    chk("b2b_done2_count", done_cnt, 32'd1);
    chk("b2b_done2_last", {31'd0, done}, 32'd1);
    chk("b2b_out2", {16'd0, out}, 32'h0400);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    chk("b2b_no_extra_done", done_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
